// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a five-stage in-order pipeline: memory-wait stalls with a
// timeout fault, branch redirects, load-use interlocks and saturating performance counters.
module pipeline_ctrl #(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_opcode,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic [1:0]  ex_branch_type,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        id_ex_bubble,
    output logic        mem_wb_bubble,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        pc_redirect,
    output logic        fault,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    // Encodings shared with the decoder's opcodes_t / branch_type_t.
    localparam logic [4:0] OP_LOAD          = 5'b00000;
    localparam logic [1:0] NON_TYPE         = 2'd0;
    localparam logic [1:0] JAL_TYPE         = 2'd1;
    localparam logic [1:0] JALR_TYPE        = 2'd2;
    localparam logic [1:0] CONDITIONAL_TYPE = 2'd3;

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic mem_stall;
    logic hold;
    logic taken;
    logic load_use;

    always_comb begin
        mem_stall = mem_req & ~mem_ack;
        // FAULT freezes the pipeline regardless of the memory handshake.
        hold      = mem_stall | (state_q == FAULT);

        unique case (ex_branch_type)
            JAL_TYPE, JALR_TYPE: taken = 1'b1;
            CONDITIONAL_TYPE:    taken = ex_branch_taken;
            NON_TYPE:            taken = 1'b0;
            default:             taken = 1'b0;
        endcase

        load_use = (ex_opcode == OP_LOAD) & ex_reg_write & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        pc_redirect   = 1'b0;

        if (hold) begin
            // EX is frozen too, so a pending taken branch survives until release.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (taken) begin
            pc_redirect   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_bubble  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            RUN: begin
                wait_d = 8'd0;
                if (mem_stall) begin
                    // The entry cycle is the first counted wait cycle.
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                    wait_d  = 8'd0;
                end else if (wait_q >= MEM_TIMEOUT) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RUN;
                wait_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (pc_redirect && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fault       = (state_q == FAULT);
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default-timeout instance and a MEM_TIMEOUT=4 instance
// share stimulus; expectations go through a FIFO scoreboard and are checked with assertions.
module tb_pipeline_ctrl;

    localparam logic [4:0] OP_LOAD = 5'b00000;
    localparam logic [4:0] OP_ALU  = 5'b01100;
    localparam logic [1:0] BT_NON  = 2'd0;
    localparam logic [1:0] BT_JAL  = 2'd1;
    localparam logic [1:0] BT_JALR = 2'd2;
    localparam logic [1:0] BT_COND = 2'd3;

    // {pc,if_id,id_ex,ex_mem stall, id_ex_bubble, mem_wb_bubble, if_id/id_ex flush, redirect, fault}
    localparam logic [9:0] C_IDLE = 10'b0000000000;
    localparam logic [9:0] C_LU   = 10'b1100100000;
    localparam logic [9:0] C_RD   = 10'b0000001110;
    localparam logic [9:0] C_MS   = 10'b1111010000;
    localparam logic [9:0] C_MSF  = 10'b1111010001;

    logic        clock = 1'b0;
    logic        nReset;
    logic [4:0]  id_rs1, id_rs2, ex_opcode, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_branch_taken, mem_req, mem_ack;
    logic [1:0]  ex_branch_type;

    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, mem_wb_bubble;
    logic        if_id_flush, id_ex_flush, pc_redirect, fault;
    logic [15:0] stall_count, flush_count;
    logic        pc_stall4, if_id_stall4, id_ex_stall4, ex_mem_stall4, id_ex_bubble4;
    logic        mem_wb_bubble4, if_id_flush4, id_ex_flush4, pc_redirect4, fault4;
    logic [15:0] stall_count4, flush_count4;
    logic [9:0]  ctrl, ctrl4;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clock = ~clock;

    pipeline_ctrl dut (
        .clock(clock), .nReset(nReset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_opcode(ex_opcode),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_branch_type(ex_branch_type),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .pc_redirect(pc_redirect),
        .fault(fault), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(8'd4)) dut4 (
        .clock(clock), .nReset(nReset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_opcode(ex_opcode),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_branch_type(ex_branch_type),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .id_ex_stall(id_ex_stall4),
        .ex_mem_stall(ex_mem_stall4), .id_ex_bubble(id_ex_bubble4),
        .mem_wb_bubble(mem_wb_bubble4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .pc_redirect(pc_redirect4), .fault(fault4), .stall_count(stall_count4),
        .flush_count(flush_count4)
    );

    assign ctrl  = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
                    mem_wb_bubble, if_id_flush, id_ex_flush, pc_redirect, fault};
    assign ctrl4 = {pc_stall4, if_id_stall4, id_ex_stall4, ex_mem_stall4, id_ex_bubble4,
                    mem_wb_bubble4, if_id_flush4, id_ex_flush4, pc_redirect4, fault4};

    task automatic push(input string tag, input logic [15:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [15:0] obs);
        logic [15:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        push(tag, exp);
        compare(obs);
    endtask

    task automatic cnt(input string tag, input logic [15:0] s, input logic [15:0] f);
        chk({tag, "_stall_count"}, stall_count, s);
        chk({tag, "_flush_count"}, flush_count, f);
    endtask

    // Inputs are applied at a falling edge and outputs sampled 1 ns later.
    task automatic step(input string tag, input logic [9:0] exp, input logic [9:0] exp4);
        push(tag, {6'b0, exp});
        push({tag, "_t4"}, {6'b0, exp4});
        #1;
        compare({6'b0, ctrl});
        compare({6'b0, ctrl4});
        @(negedge clock);
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_opcode = OP_ALU; ex_rd = 5'd0; ex_reg_write = 1'b0;
        ex_branch_type = BT_NON; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        nReset = 1'b0;
        clear_in();
        #1;
        chk("rst_ctrl", {6'b0, ctrl}, 16'd0);
        chk("rst_ctrl_t4", {6'b0, ctrl4}, 16'd0);
        cnt("rst", 16'd0, 16'd0);
        @(negedge clock);
        nReset = 1'b1;

        ex_opcode = OP_LOAD; ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        step("lu_rs2", C_LU, C_LU);
        cnt("lu_rs2", 16'd1, 16'd0);
        clear_in();
        step("lu_clear", C_IDLE, C_IDLE);
        cnt("lu_clear", 16'd1, 16'd0);

        ex_opcode = OP_LOAD; ex_rd = 5'd0; ex_reg_write = 1'b1;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        step("x0_dest", C_IDLE, C_IDLE);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs2 = 1'b0;
        step("lu_rs1", C_LU, C_LU);
        id_uses_rs1 = 1'b0;
        step("lu_rs1_unused", C_IDLE, C_IDLE);
        id_uses_rs1 = 1'b1; ex_reg_write = 1'b0;
        step("lu_no_write", C_IDLE, C_IDLE);
        cnt("lu_rs1", 16'd2, 16'd0);

        clear_in();
        ex_opcode = OP_LOAD; ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        ex_branch_type = BT_COND; ex_branch_taken = 1'b1;
        step("br_over_lu", C_RD, C_RD);
        cnt("br_over_lu", 16'd2, 16'd1);
        clear_in();
        ex_branch_type = BT_COND;
        step("cond_not_taken", C_IDLE, C_IDLE);
        ex_branch_type = BT_NON; ex_branch_taken = 1'b1;
        step("non_type", C_IDLE, C_IDLE);
        clear_in();
        ex_branch_type = BT_JALR;
        step("jalr", C_RD, C_RD);
        cnt("jalr", 16'd2, 16'd2);

        clear_in();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait", C_MS, C_MS);
        mem_ack = 1'b1;
        step("mem_ack", C_IDLE, C_IDLE);
        clear_in();
        step("mem_done", C_IDLE, C_IDLE);
        cnt("mem_wait", 16'd5, 16'd2);

        ex_branch_type = BT_JAL; mem_req = 1'b1;
        for (int i = 0; i < 2; i++) step("jal_held", C_MS, C_MS);
        mem_ack = 1'b1;
        step("jal_release", C_RD, C_RD);
        cnt("jal_release", 16'd7, 16'd3);
        clear_in();
        step("jal_clear", C_IDLE, C_IDLE);

        ex_opcode = OP_LOAD; ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        mem_req = 1'b1;
        step("mem_over_lu", C_MS, C_MS);
        mem_ack = 1'b1;
        step("lu_after_ack", C_LU, C_LU);
        cnt("prio", 16'd9, 16'd3);
        clear_in();
        step("prio_clear", C_IDLE, C_IDLE);

        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) step("timeout_wait", C_MS, C_MS);
        cnt("timeout", 16'd14, 16'd3);
        mem_ack = 1'b1;
        step("timeout_ack", C_IDLE, C_MSF);
        mem_req = 1'b0; mem_ack = 1'b0;
        step("fault_sticky", C_IDLE, C_MSF);
        mem_req = 1'b1;
        step("rewait", C_MS, C_MSF);
        cnt("rewait", 16'd15, 16'd3);

        // Asynchronous reset with dut in MEM_WAIT and dut4 in FAULT.
        mem_req = 1'b0;
        #2 nReset = 1'b0;
        #1;
        chk("midrst_ctrl", {6'b0, ctrl}, 16'd0);
        chk("midrst_ctrl_t4", {6'b0, ctrl4}, 16'd0);
        cnt("midrst", 16'd0, 16'd0);
        chk("midrst_stall_t4", stall_count4, 16'd0);
        chk("midrst_flush_t4", flush_count4, 16'd0);
        @(negedge clock);
        nReset = 1'b1;

        ex_opcode = OP_LOAD; ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        step("post_rst_lu", C_LU, C_LU);
        cnt("post_rst", 16'd1, 16'd0);
        clear_in();
        step("post_rst_clear", C_IDLE, C_IDLE);

        mem_req = 1'b1;
        for (int k = 1; k <= 70000; k++) begin
            @(negedge clock);
            if (k == 255) chk("fault_default_before", {15'b0, fault}, 16'd0);
            if (k == 256) chk("fault_default_after", {15'b0, fault}, 16'd1);
            if (k == 65533) chk("stall_near_sat", stall_count, 16'hFFFE);
        end
        chk("sat_ctrl", {6'b0, ctrl}, {6'b0, C_MSF});
        chk("sat_ctrl_t4", {6'b0, ctrl4}, {6'b0, C_MSF});
        cnt("sat", 16'hFFFF, 16'd0);
        chk("sat_stall_t4", stall_count4, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8'd255: max consecutive data-memory wait cycles before fault.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 nReset  in  1  asynchronous, active-low reset.
REQ-004 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
REQ-006 ex_opcode  in  5  opcodes_t of the instruction in EX.
REQ-007 ex_rd  in  5  destination register in EX; ex_reg_write  in  1  EX writes rd.
REQ-008 ex_branch_type  in  2  branch_type_t in EX; ex_branch_taken  in  1  condition result (CONDITIONAL_TYPE only).
REQ-009 mem_req  in  1  MEM stage holds a LOAD/STORE; mem_ack  in  1  data memory completes this cycle.
REQ-010 pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the named register.
REQ-011 id_ex_bubble, mem_wb_bubble  out  1 each  load NOP control into the named register.
REQ-012 if_id_flush, id_ex_flush  out  1 each  squash the named register; pc_redirect  out  1  PC takes EX target.
REQ-013 fault  out  1  sticky memory-timeout flag.
REQ-014 stall_count, flush_count  out  16 each  saturating performance counters.

Function
REQ-015 FSM states RUN, MEM_WAIT, FAULT (2-bit); reset state RUN.
REQ-016 mem_stall = mem_req & ~mem_ack, valid in RUN and MEM_WAIT.
REQ-017 RUN -> MEM_WAIT when mem_stall; MEM_WAIT -> RUN when mem_ack; MEM_WAIT -> FAULT when wait counter reaches MEM_TIMEOUT with mem_ack low; FAULT exits only by reset.
REQ-018 Wait counter: 8-bit, cleared in RUN, +1 per MEM_WAIT cycle without mem_ack; the wait is counted from the first stalling cycle, so FAULT entry occurs MEM_TIMEOUT+1 stall cycles after the request.
REQ-019 Memory stall (mem_stall, or state FAULT): pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1, mem_wb_bubble = 1; all flush, redirect and id_ex_bubble = 0.
REQ-020 Taken = JAL_TYPE | JALR_TYPE | (CONDITIONAL_TYPE & ex_branch_taken); NON_TYPE never taken.
REQ-021 Redirect, when taken and no memory stall: pc_redirect, if_id_flush, id_ex_flush = 1 for exactly that cycle; all stalls 0.
REQ-022 Load-use hazard = ex_opcode==LOAD & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-023 Load-use, when no memory stall and no redirect: pc_stall, if_id_stall, id_ex_bubble = 1 for one cycle; ex_mem_stall = 0.
REQ-024 Priority: memory stall > redirect > load-use; redirect suppresses load-use (ID squashed).
REQ-025 A taken branch in EX during a memory stall is held, not lost; redirect fires in the first non-stalled cycle.
REQ-026 All control outputs are combinational from state and inputs; no added latency.
REQ-027 stall_count +1 each cycle pc_stall=1; flush_count +1 each cycle pc_redirect=1; both hold at 16'hFFFF.
REQ-028 x0 destination never creates a hazard.

Reset
REQ-029 nReset low: state RUN, wait counter 0, fault 0, stall_count 0, flush_count 0, immediately and independent of clock.
REQ-030 Reset asserted mid-MEM_WAIT or in FAULT returns to RUN with all stall/flush outputs 0 while mem_req low.
REQ-031 After nReset release, first rising edge operates normally.

Verification
REQ-032 LOAD to x5 in EX, ID uses rs2=x5 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1; stall_count=1; next cycle clear.
REQ-033 CONDITIONAL_TYPE, ex_branch_taken=1, simultaneous load-use -> pc_redirect=if_id_flush=id_ex_flush=1, id_ex_bubble=0, flush_count=1.
REQ-034 mem_req=1, mem_ack low 3 cycles then high -> 3 cycles full stall + mem_wb_bubble, state RUN after ack, stall_count=3.
REQ-035 MEM_TIMEOUT=4, mem_ack never high -> fault=1 after 5 stall cycles, stays 1; nReset pulse -> fault=0, counters 0.
REQ-036 JAL in EX during 2-cycle memory stall -> no redirect during stall, pc_redirect=1 on release cycle.
REQ-037 Force 70000 stall cycles -> stall_count saturates at 16'hFFFF.
